// File: rtl/ocp_defs.sv
// Shared OCP encodings and arbiter FSM states, also used by the OCP slave controller.
package ocp_defs;

  localparam logic [2:0] MCmdIdle = 3'b000;
  localparam logic [2:0] MCmdWr   = 3'b001;
  localparam logic [2:0] MCmdRd   = 3'b010;

  localparam logic [1:0] SRespNull = 2'b00;
  localparam logic [1:0] SRespDva  = 2'b01;
  localparam logic [1:0] SRespFail = 2'b10;
  localparam logic [1:0] SRespErr  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCmd  = 2'b01,
    StResp = 2'b10
  } state_e;

  // Undefined MCmd encodings count as IDLE.
  function automatic logic is_req(input logic [2:0] cmd);
    return (cmd == MCmdWr) || (cmd == MCmdRd);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: scans lg+1, lg+2, ... modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] lg_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] cand;
  logic            found;

  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(lg_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/ocp_master_arbiter.sv
// Shares one OCP slave port among NUM_MASTERS masters, round-robin, one transaction in flight.
module ocp_master_arbiter
  import ocp_defs::*;
#(
  parameter int unsigned NUM_MASTERS  = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [3*NUM_MASTERS-1:0]      m_MCmd,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_MAddr,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_MData,
  output logic [NUM_MASTERS-1:0]        m_SCmdAccept,
  output logic [2*NUM_MASTERS-1:0]      m_SResp,
  output logic [DATA_W-1:0]             m_SData,
  output logic [2:0]                    s_MCmd,
  output logic [ADDR_W-1:0]             s_MAddr,
  output logic [DATA_W-1:0]             s_MData,
  input  logic                          s_SCmdAccept,
  input  logic [1:0]                    s_SResp,
  input  logic [DATA_W-1:0]             s_SData,
  output logic [NUM_MASTERS-1:0]        grant
);

  localparam int unsigned IdxW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned TcntW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(RESP_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        g_q, g_d;
  logic [IdxW-1:0]        lg_q, lg_d;
  logic [TcntW-1:0]       tcnt_q, tcnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [2:0]             cmd_a  [NUM_MASTERS];
  logic [ADDR_W-1:0]      addr_a [NUM_MASTERS];
  logic [DATA_W-1:0]      data_a [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] req;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IdxW-1:0]        arb_idx;
  logic                   arb_any;

  logic [2:0]             g_cmd;
  logic                   g_valid;
  logic                   timeout_hit;
  logic [1:0]             resp_g;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign cmd_a[i]  = m_MCmd[3*i +: 3];
    assign addr_a[i] = m_MAddr[ADDR_W*i +: ADDR_W];
    assign data_a[i] = m_MData[DATA_W*i +: DATA_W];
    assign req[i]    = is_req(cmd_a[i]);
  end

  rr_arbiter #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i (req),
    .lg_i  (lg_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign g_cmd       = cmd_a[g_q];
  assign g_valid     = is_req(g_cmd);
  assign timeout_hit = (tcnt_q == TcntLast) && (s_SResp == SRespNull);
  assign resp_g      = timeout_hit ? SRespErr : s_SResp;
  assign grant       = grant_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    lg_d    = lg_q;
    tcnt_d  = tcnt_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d = StCmd;
          g_d     = arb_idx;
          grant_d = arb_gnt;
        end
      end
      StCmd: begin
        // A master dropping its command abandons the slot, even if accept coincides.
        if (!g_valid) begin
          state_d = StIdle;
          lg_d    = g_q;
          grant_d = '0;
        end else if (s_SCmdAccept) begin
          if (g_cmd == MCmdWr) begin
            state_d = StIdle;
            lg_d    = g_q;
            grant_d = '0;
          end else begin
            state_d = StResp;
            tcnt_d  = '0;
          end
        end
      end
      StResp: begin
        if ((s_SResp != SRespNull) || (tcnt_q == TcntLast)) begin
          state_d = StIdle;
          lg_d    = g_q;
          grant_d = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      lg_q    <= IdxW'(NUM_MASTERS - 1);
      tcnt_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lg_q    <= lg_d;
      tcnt_q  <= tcnt_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    s_MCmd       = MCmdIdle;
    s_MAddr      = '0;
    s_MData      = '0;
    m_SData      = '0;
    m_SCmdAccept = '0;
    m_SResp      = '0;
    if (state_q == StCmd) begin
      if (g_valid) begin
        s_MCmd = g_cmd;
      end
      s_MAddr = addr_a[g_q];
      s_MData = data_a[g_q];
    end
    if (state_q == StResp) begin
      m_SData = s_SData;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (g_q == IdxW'(i)) begin
        if (state_q == StCmd) begin
          m_SCmdAccept[i] = s_SCmdAccept & g_valid;
        end
        if (state_q == StResp) begin
          m_SResp[2*i +: 2] = resp_g;
        end
      end
    end
  end

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Directed bench for ocp_master_arbiter with two masters and a short response timeout.
module tb_ocp_master_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [3*NM-1:0]   m_MCmd;
  logic [AW*NM-1:0]  m_MAddr;
  logic [DW*NM-1:0]  m_MData;
  logic [NM-1:0]     m_SCmdAccept;
  logic [2*NM-1:0]   m_SResp;
  logic [DW-1:0]     m_SData;
  logic [2:0]        s_MCmd;
  logic [AW-1:0]     s_MAddr;
  logic [DW-1:0]     s_MData;
  logic              s_SCmdAccept;
  logic [1:0]        s_SResp;
  logic [DW-1:0]     s_SData;
  logic [NM-1:0]     grant;

  int checks   = 0;
  int failures = 0;

  ocp_master_arbiter #(
    .NUM_MASTERS  (NM),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .RESP_TIMEOUT (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .m_MCmd       (m_MCmd),
    .m_MAddr      (m_MAddr),
    .m_MData      (m_MData),
    .m_SCmdAccept (m_SCmdAccept),
    .m_SResp      (m_SResp),
    .m_SData      (m_SData),
    .s_MCmd       (s_MCmd),
    .s_MAddr      (s_MAddr),
    .s_MData      (s_MData),
    .s_SCmdAccept (s_SCmdAccept),
    .s_SResp      (s_SResp),
    .s_SData      (s_SData),
    .grant        (grant)
  );

  always #5 clock = ~clock;

  // Advance one cycle; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after new inputs, still far from the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d);
    m_MCmd[3*i +: 3]    = c;
    m_MAddr[32*i +: 32] = a;
    m_MData[32*i +: 32] = d;
  endtask

  initial begin
    reset        = 1'b0;
    m_MCmd       = '0;
    m_MAddr      = '0;
    m_MData      = '0;
    s_SCmdAccept = 1'b0;
    s_SResp      = 2'b00;
    s_SData      = '0;

    // Reset state
    tick();
    settle();
    chk("rst_grant", grant, 0);
    chk("rst_s_mcmd", s_MCmd, 0);
    chk("rst_accept", m_SCmdAccept, 0);
    chk("rst_sresp", m_SResp, 0);
    chk("rst_s_maddr", s_MAddr, 0);
    chk("rst_m_sdata", m_SData, 0);
    tick();

    // Single write from m0
    reset = 1'b1;
    set_cmd(0, 3'b001, 32'h10, 32'hA5);
    s_SCmdAccept = 1'b1;
    settle();
    chk("wr_bubble_s_mcmd", s_MCmd, 0);
    chk("wr_bubble_accept", m_SCmdAccept, 0);
    tick();
    settle();
    chk("wr_s_mcmd", s_MCmd, 3'b001);
    chk("wr_s_maddr", s_MAddr, 32'h10);
    chk("wr_s_mdata", s_MData, 32'hA5);
    chk("wr_accept", m_SCmdAccept, 2'b01);
    chk("wr_grant", grant, 2'b01);
    tick();
    set_cmd(0, 3'b000, 0, 0);
    settle();
    chk("wr_after_grant", grant, 0);
    chk("wr_after_accept", m_SCmdAccept, 0);

    // Single read from m1, DVA on third RESP cycle
    set_cmd(1, 3'b010, 32'h20, 0);
    tick();
    settle();
    chk("rd_s_mcmd", s_MCmd, 3'b010);
    chk("rd_s_maddr", s_MAddr, 32'h20);
    chk("rd_accept", m_SCmdAccept, 2'b10);
    chk("rd_grant", grant, 2'b10);
    tick();
    set_cmd(1, 3'b000, 0, 0);
    settle();
    chk("rd_resp1_sresp", m_SResp, 0);
    chk("rd_resp1_s_mcmd", s_MCmd, 0);
    tick();
    settle();
    chk("rd_resp2_sresp", m_SResp, 0);
    tick();
    s_SResp = 2'b01;
    s_SData = 32'hDEADBEEF;
    settle();
    chk("rd_dva_sresp", m_SResp, 4'b0100);
    chk("rd_dva_sdata", m_SData, 32'hDEADBEEF);
    tick();
    s_SResp = 2'b00;
    s_SData = 0;
    settle();
    chk("rd_done_grant", grant, 0);
    chk("rd_done_sresp", m_SResp, 0);

    // Round-robin: both masters write continuously; last served was m1
    set_cmd(0, 3'b001, 32'h100, 32'h1);
    set_cmd(1, 3'b001, 32'h200, 32'h2);
    tick();
    settle();
    chk("rr_grant0", grant, 2'b01);
    chk("rr_addr0", s_MAddr, 32'h100);
    tick();
    settle();
    chk("rr_idle0", grant, 0);
    tick();
    settle();
    chk("rr_grant1", grant, 2'b10);
    chk("rr_addr1", s_MAddr, 32'h200);
    tick();
    settle();
    chk("rr_idle1", grant, 0);
    tick();
    settle();
    chk("rr_grant2", grant, 2'b01);
    tick();
    tick();
    settle();
    chk("rr_grant3", grant, 2'b10);
    chk("rr_accept3", m_SCmdAccept, 2'b10);
    tick();
    set_cmd(0, 3'b000, 0, 0);
    set_cmd(1, 3'b000, 0, 0);
    settle();

    // Timeout: m0 read, slave silent, ERR on 4th RESP cycle, late DVA dropped
    set_cmd(0, 3'b010, 32'h30, 0);
    tick();
    settle();
    chk("to_grant", grant, 2'b01);
    tick();
    set_cmd(0, 3'b000, 0, 0);
    settle();
    chk("to_resp1", m_SResp, 0);
    tick();
    settle();
    chk("to_resp2", m_SResp, 0);
    tick();
    settle();
    chk("to_resp3", m_SResp, 0);
    tick();
    settle();
    chk("to_err", m_SResp, 4'b0011);
    tick();
    s_SResp = 2'b01;
    s_SData = 32'h1234;
    settle();
    chk("to_late_sresp", m_SResp, 0);
    chk("to_late_sdata", m_SData, 0);
    chk("to_late_grant", grant, 0);
    tick();
    s_SResp = 2'b00;
    s_SData = 0;

    // Stalled accept: 5 cycles without accept, then accept
    set_cmd(0, 3'b001, 32'h40, 32'h55);
    s_SCmdAccept = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("stall_s_mcmd", s_MCmd, 3'b001);
      chk("stall_s_maddr", s_MAddr, 32'h40);
      chk("stall_accept", m_SCmdAccept, 0);
      tick();
    end
    s_SCmdAccept = 1'b1;
    settle();
    chk("stall_go_accept", m_SCmdAccept, 2'b01);
    chk("stall_go_s_mdata", s_MData, 32'h55);
    tick();
    set_cmd(0, 3'b000, 0, 0);
    settle();
    chk("stall_after_accept", m_SCmdAccept, 0);
    chk("stall_after_grant", grant, 0);

    // Reset during RESP of an m1 read; m0 must win afterwards
    set_cmd(1, 3'b010, 32'h50, 0);
    tick();
    settle();
    chk("mr_grant", grant, 2'b10);
    tick();
    set_cmd(1, 3'b000, 0, 0);
    settle();
    chk("mr_in_resp", grant, 2'b10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_cmd(0, 3'b001, 32'h60, 0);
    set_cmd(1, 3'b001, 32'h70, 0);
    settle();
    chk("mr_grant_cleared", grant, 0);
    chk("mr_s_mcmd", s_MCmd, 0);
    chk("mr_sresp", m_SResp, 0);
    tick();
    settle();
    chk("mr_m0_wins", grant, 2'b01);
    chk("mr_m0_addr", s_MAddr, 32'h60);
    tick();
    set_cmd(0, 3'b000, 0, 0);
    set_cmd(1, 3'b000, 0, 0);

    // m0 drops its command in CMD while the slave accepts: accept ignored
    set_cmd(0, 3'b001, 32'h80, 0);
    s_SCmdAccept = 1'b0;
    tick();
    settle();
    chk("drop_grant", grant, 2'b01);
    set_cmd(0, 3'b000, 0, 0);
    s_SCmdAccept = 1'b1;
    settle();
    chk("drop_accept", m_SCmdAccept, 0);
    chk("drop_s_mcmd", s_MCmd, 0);
    tick();
    settle();
    chk("drop_grant_after", grant, 0);
    chk("drop_sresp", m_SResp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ocp_master_arbiter.md
Name: ocp_master_arbiter

Overview:
- Shares one OCP slave port, served by the team's OCP slave controller, between NUM_MASTERS OCP masters.
- Arbitration is round-robin, one outstanding transaction at a time.
- Reads block the port until the slave responds or a response timeout fires.
- Writes are posted and complete on SCmdAccept.
- Sits between the master-side interconnect and the single slave.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 32, MAddr width
DATA_W, 32, MData/SData width
RESP_TIMEOUT, 16, cycles in RESP with SResp=NULL before the arbiter returns ERR (>=1)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
m_MCmd  in  3*NUM_MASTERS  per-master command; master i at bits [3i+2:3i]
m_MAddr  in  ADDR_W*NUM_MASTERS  per-master address
m_MData  in  DATA_W*NUM_MASTERS  per-master write data
m_SCmdAccept  out  NUM_MASTERS  per-master command accept
m_SResp  out  2*NUM_MASTERS  per-master response
m_SData  out  DATA_W  read data, broadcast; valid only where m_SResp[g]=DVA
s_MCmd  out  3  command to slave
s_MAddr  out  ADDR_W  address to slave
s_MData  out  DATA_W  write data to slave
s_SCmdAccept  in  1  slave accept
s_SResp  in  2  slave response
s_SData  in  DATA_W  slave read data
grant  out  NUM_MASTERS  one-hot current owner; 0 when idle

Behaviour:
- Encodings. MCmd: IDLE=3'b000, WR=3'b001, RD=3'b010; other values are treated as IDLE (ignored). SResp: NULL=2'b00, DVA=2'b01, FAIL=2'b10, ERR=2'b11.
- Registered state: fsm state, grant index g, last-served index lg, timeout counter tcnt (clog2(RESP_TIMEOUT+1) bits).
- Reset (reset=0 at a clock edge):
  - state=IDLE, grant=0, lg=NUM_MASTERS-1 (master 0 wins first), tcnt=0.
  - Outputs while in IDLE: s_MCmd=IDLE, m_SCmdAccept=0, m_SResp all NULL, s_MAddr/s_MData/m_SData=0.
  - Reset mid-transaction abandons it immediately; no response is issued.
- IDLE:
  - If any master has MCmd WR or RD, pick the first requester scanning lg+1, lg+2, ... modulo NUM_MASTERS.
  - Register g, drive grant one-hot, go to CMD.
  - One-cycle arbitration bubble; nothing is forwarded in IDLE.
- CMD:
  - s_MCmd/s_MAddr/s_MData are combinational muxes of master g.
  - m_SCmdAccept[g] = s_SCmdAccept, same cycle; all other accepts are 0.
  - On s_SCmdAccept=1 with WR: go to IDLE, lg<=g.
  - On s_SCmdAccept=1 with RD: go to RESP, tcnt<=0.
  - If master g drops MCmd to IDLE before accept (protocol violation): go to IDLE, lg<=g, no response.
  - Accept that arrives in the same cycle as the drop is ignored.
- RESP:
  - s_MCmd=IDLE.
  - m_SResp[g]=s_SResp and m_SData=s_SData, combinational; other masters see NULL.
  - If s_SResp!=NULL: go to IDLE, lg<=g.
  - Otherwise tcnt increments.
  - When tcnt==RESP_TIMEOUT-1 and s_SResp==NULL: drive m_SResp[g]=ERR for that cycle, go to IDLE, lg<=g.
  - A late slave response arriving after timeout is dropped.
- Latency:
  - Write, from request to accept: min 2 cycles (IDLE, CMD).
  - Read, from request to response: min 3 cycles (IDLE, CMD, RESP).
- Fairness: a master that keeps requesting is served at most once per NUM_MASTERS grants while others request.
- Non-granted masters must hold MCmd (OCP rule); the arbiter never accepts them.

Decomposition:
- Shared package/header ocp_defs: MCmd and SResp encodings, FSM state constants (IDLE, CMD, RESP). The team's OCP slave controller uses the same package.
- One sub-module: rr_arbiter.
  - Inputs: req[NUM_MASTERS], lg.
  - Outputs: one-hot gnt, index, any.
  - Purely combinational rotating priority.
- Muxes, FSM and counter stay in the top module.

Test Plan:
- Single write: reset low for 2 cycles, then m0 MCmd=WR, MAddr=0x10, MData=0xA5, slave accepts immediately. Required: s_MCmd=WR with MAddr/MData forwarded in cycle 2, m_SCmdAccept[0]=1 in that cycle, grant=0 in the next cycle.
- Single read: m1 RD at 0x20; slave accepts, then returns DVA with 0xDEADBEEF after 3 cycles. Required: m_SResp[1]=DVA and m_SData=0xDEADBEEF in the same cycle; m_SResp[0] stays NULL.
- Round-robin: m0 and m1 both request WR continuously, slave always accepts. Required: grant order m0, m1, m0, m1; each write takes 2 cycles.
- Timeout: RESP_TIMEOUT=4, m0 RD accepted, slave never responds. Required: m_SResp[0]=ERR on the 4th RESP cycle, then IDLE; a DVA arriving 1 cycle later is not forwarded.
- Stalled accept: slave holds s_SCmdAccept=0 for 5 cycles, then 1. Required: s_MCmd held stable, m_SCmdAccept[0]=0 throughout, then 1 in the accept cycle only.
- Reset mid-read: assert reset in RESP. Required: next cycle grant=0, s_MCmd=IDLE, all m_SResp NULL, and m0 wins the next arbitration.
